// File: rtl/calc_pkg.sv
// Shared definitions for the signed calculator datapath:
// opcode values, adder/subtractor FSM states and sizing helpers.
package calc_pkg;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int digit_count(
    input int w,
    input int d
  );
    return w / d;
  endfunction

  function automatic int cnt_width(
    input int w,
    input int d
  );
    return $clog2(w / d) + 1;
  endfunction

endpackage

// File: rtl/addsub_digit_slice.sv
// Combinational DIGIT-bit ripple of full-adder / full-subtractor
// cells; bin/bout carry the carry (add) or the borrow (sub).
module addsub_digit_slice
  import calc_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             op,
  input  logic             bin,
  output logic [DIGIT-1:0] r_d,
  output logic             bout
);

  logic c;

  always_comb begin
    c   = bin;
    r_d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      r_d[i] = a_d[i] ^ b_d[i] ^ c;
      if (op == OP_ADD) begin
        c = (a_d[i] & b_d[i])
          | (c & (a_d[i] ^ b_d[i]));
      end else begin
        c = (~a_d[i] & b_d[i])
          | (c & ~(a_d[i] ^ b_d[i]));
      end
    end
    bout = c;
  end

endmodule

// File: rtl/seq_signed_addsub.sv
// Multi-cycle signed add/sub, DIGIT bits per cycle, LSB first.
// Define SEQ_ADDSUB_SATURATE_EN to clamp the result on overflow.
module seq_signed_addsub
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("seq_signed_addsub: bad WIDTH/DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             op_q, op_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bo_q, bo_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic [DIGIT-1:0] sl_r;
  logic             sl_bout;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] r_fin;
  logic             ovf_fin;

  addsub_digit_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a_d (a_sh_q[DIGIT-1:0]),
    .b_d (b_sh_q[DIGIT-1:0]),
    .op  (op_q),
    .bin (carry_q),
    .r_d (sl_r),
    .bout(sl_bout)
  );

  // New digit enters at the top so the LSB ends at bit 0.
  always_comb begin
    r_next = r_sh_q >> DIGIT;
    r_next[WIDTH-1 -: DIGIT] = sl_r;
    if (op_q == OP_ADD) begin
      ovf_fin = (a_msb_q == b_msb_q)
              & (r_next[WIDTH-1] != a_msb_q);
    end else begin
      ovf_fin = (a_msb_q != b_msb_q)
              & (r_next[WIDTH-1] != a_msb_q);
    end
    r_fin = r_next;
`ifdef SEQ_ADDSUB_SATURATE_EN
    if (ovf_fin) begin
      r_fin = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                      : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    op_d    = op_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    done_d  = 1'b0;
    res_d   = res_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          carry_d = 1'b0;
          op_d    = op;
          a_sh_d  = a;
          b_sh_d  = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        r_sh_d  = r_next;
        carry_d = sl_bout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          res_d   = r_fin;
          bo_d    = sl_bout;
          ovf_d   = ovf_fin;
          zero_d  = (r_fin == '0);
          neg_d   = r_fin[WIDTH-1];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      done_q  <= done_d;
      res_q   <= res_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;
  assign result     = res_q;
  assign borrow_out = bo_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;
  assign negative   = neg_q;

endmodule

// File: tb/tb_seq_signed_addsub.sv
// Bench for seq_signed_addsub: directed corner cases plus random
// operations checked against an integer-arithmetic model.
module tb_seq_signed_addsub;

  localparam int W   = 8;
  localparam int DIG = 2;
  localparam int N   = W / DIG;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic         borrow_out, overflow;
  logic         zero, negative;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] prev_r = '0;

  seq_signed_addsub #(
    .WIDTH(W),
    .DIGIT(DIG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .borrow_out(borrow_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void model(
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       o,
    output logic [7:0] r,
    output logic       bo,
    output logic       ov,
    output logic       z,
    output logic       n
  );
    int sx, sy, ux, uy, s;
    sx = $signed(x);
    sy = $signed(y);
    ux = int'(x);
    uy = int'(y);
    if (o) begin
      s  = sx + sy;
      bo = (ux + uy) > 255;
    end else begin
      s  = sx - sy;
      bo = ux < uy;
    end
    ov = (s > 127) || (s < -128);
    r  = 8'(s);
`ifdef SEQ_ADDSUB_SATURATE_EN
    if (ov) r = x[7] ? 8'h80 : 8'h7F;
`endif
    z = (r == 8'h00);
    n = r[7];
  endfunction

  task automatic launch(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       o
  );
    a     = x;
    b     = y;
    op    = o;
    start = 1'b1;
  endtask

  task automatic finish(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       o,
    input bit         mid
  );
    logic [7:0] er;
    logic       eb, eo, ez, en;
    int         lat;
    model(x, y, o, er, eb, eo, ez, en);
    @(posedge clk);
    #1;
    start = 1'b0;
    a  = W'($urandom);
    b  = W'($urandom);
    op = 1'($urandom);
    chk("busy_start", busy, 1);
    lat = 0;
    for (int k = 1; k <= 4 * N + 4 && lat == 0; k++) begin
      if (mid && k == 2) begin
        @(negedge clk);
        start = 1'b1;
        a  = ~x;
        b  = y + 8'd1;
        op = ~o;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = k;
      end else begin
        chk("busy_run", busy, 1);
        chk("hold", result, prev_r);
      end
    end
    chk("latency", lat, N);
    chk("busy_done", busy, 0);
    chk("result", result, er);
    chk("borrow", borrow_out, eb);
    chk("overflow", overflow, eo);
    chk("zero", zero, ez);
    chk("negative", negative, en);
    prev_r = er;
  endtask

  task automatic run_op(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       o,
    input bit         mid
  );
    @(negedge clk);
    launch(x, y, o);
    finish(x, y, o, mid);
    @(posedge clk);
    #1;
    chk("done_pulse", done, 0);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_borrow"}, borrow_out, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_zero"}, zero, 0);
    chk({tag, "_neg"}, negative, 0);
  endtask

  initial begin
    #12;
    chk_zero_outs("reset");
    @(negedge clk);
    rst = 1'b1;

    run_op(8'd5, 8'd3, 1'b0, 0);
    run_op(8'd3, 8'd5, 1'b0, 0);
    run_op(8'h80, 8'd1, 1'b0, 0);
    run_op(8'd100, 8'd100, 1'b1, 0);
    run_op(8'd7, 8'd7, 1'b0, 0);
    run_op(8'hFF, 8'd1, 1'b1, 0);
    run_op(8'h7F, 8'hFF, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b1, 0);

    run_op(8'd9, 8'd4, 1'b0, 1);

    @(negedge clk);
    launch(8'd20, 8'd30, 1'b1);
    finish(8'd20, 8'd30, 1'b1, 0);
    launch(8'hF0, 8'h10, 1'b0);
    finish(8'hF0, 8'h10, 1'b0, 0);
    @(posedge clk);
    #1;
    chk("b2b_pulse", done, 0);

    repeat (60) begin
      run_op(W'($urandom), W'($urandom),
             1'($urandom), 0);
    end

    run_op(8'd3, 8'd5, 1'b0, 0);
    @(negedge clk);
    launch(8'd5, 8'd3, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_zero_outs("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    prev_r = '0;
    for (int k = 0; k < 3 * N; k++) begin
      @(posedge clk);
      #1;
      chk("no_done", done, 0);
      chk("idle", busy, 0);
    end
    run_op(8'd5, 8'd3, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
